// File: rtl/conv55_ctrl.sv
// conv55_ctrl: sequencing controller for the 5x5 convolution engine.
// Streams a MAP_SIZE x MAP_SIZE raster map into the engine, clears its line
// buffer per map, and tags each valid window result with its output coordinates.
module conv55_ctrl #(
    parameter int unsigned MAP_SIZE = 32,
    parameter int unsigned MULT_LAT = 1,
    localparam int unsigned CW = $clog2(MAP_SIZE),
    localparam int unsigned OW = $clog2(MAP_SIZE - 4)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    output logic          busy_o,
    output logic          done_o,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    output logic          conv_shift_n_o,
    output logic          conv_clr_n_o,
    output logic          out_valid_o,
    output logic [OW-1:0] out_row_o,
    output logic [OW-1:0] out_col_o,
    output logic          out_last_o
);

    localparam int unsigned PD = 1 + MULT_LAT;                 // tag pipeline depth
    localparam int unsigned DW = $clog2(MULT_LAT + 1) + 1;     // drain counter width
    localparam int unsigned TW = 2 * OW + 2;                   // {valid,row,col,last}

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] r_q, r_d;
    logic [CW-1:0] c_q, c_d;
    logic [DW-1:0] drain_q, drain_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          in_ready_q, in_ready_d;
    logic          clr_n_q, clr_n_d;
    logic [TW-1:0] tag_q [PD];
    logic [TW-1:0] tag_d;

    logic accept_c;
    logic win_c;
    logic last_px_c;
    logic last_col_c;

    assign accept_c   = in_valid_i & in_ready_q;
    assign last_col_c = (c_q == CW'(MAP_SIZE - 1));
    assign last_px_c  = last_col_c && (r_q == CW'(MAP_SIZE - 1));
    // Windows with c < 4 straddle a row boundary in the line buffer
    assign win_c      = accept_c && (r_q >= CW'(4)) && (c_q >= CW'(4));

    // Next-state, pixel counters and registered-output decode
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        drain_d = drain_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                r_d     = '0;
                c_d     = '0;
                state_d = S_STREAM;
            end
            S_STREAM: begin
                if (accept_c) begin
                    if (last_col_c) begin
                        c_d = '0;
                        r_d = r_q + CW'(1);
                        if (last_px_c) begin
                            r_d     = '0;
                            drain_d = DW'(MULT_LAT);
                            state_d = S_DRAIN;
                        end
                    end else begin
                        c_d = c_q + CW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q == '0) state_d = S_DONE;
                else               drain_d = drain_q - DW'(1);
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
        in_ready_d = (state_d == S_STREAM);
        clr_n_d    = (state_d != S_CLEAR);

        tag_d = '0;
        if (win_c) begin
            tag_d = {1'b1, OW'(r_q - CW'(4)), OW'(c_q - CW'(4)), last_px_c};
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            r_q        <= '0;
            c_q        <= '0;
            drain_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            in_ready_q <= 1'b0;
            clr_n_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            c_q        <= c_d;
            drain_q    <= drain_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            in_ready_q <= in_ready_d;
            clr_n_q    <= clr_n_d;
        end
    end

    // Free-running tag pipeline, aligned with the engine multiplier latency
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(PD); i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= tag_d;
            for (int i = 1; i < int'(PD); i++) tag_q[i] <= tag_q[i-1];
        end
    end

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign in_ready_o     = in_ready_q;
    assign conv_clr_n_o   = clr_n_q;
    assign conv_shift_n_o = ~accept_c;
    assign out_valid_o    = tag_q[PD-1][TW-1];
    assign out_row_o      = tag_q[PD-1][TW-2 -: OW];
    assign out_col_o      = tag_q[PD-1][OW:1];
    assign out_last_o     = tag_q[PD-1][0];

endmodule

// File: tb/tb_conv55_ctrl.sv
// Testbench for conv55_ctrl: scoreboard of expected tagged results per map.
module tb_conv55_ctrl;

    localparam int MS   = 32;
    localparam int ML   = 1;
    localparam int LAT  = 1 + ML;
    localparam int NRES = (MS - 4) * (MS - 4);

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic       busy, done, in_ready, conv_shift_n, conv_clr_n;
    logic       out_valid, out_last;
    logic [4:0] out_row, out_col;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int cyc;
        int row;
        int col;
        bit last;
    } exp_t;

    exp_t sb[$];
    int   nov[$];

    int res_first, res_lastv, res_donev, res_count, res_nlast;

    conv55_ctrl #(.MAP_SIZE(MS), .MULT_LAT(ML)) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start),
        .busy_o         (busy),
        .done_o         (done),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .conv_shift_n_o (conv_shift_n),
        .conv_clr_n_o   (conv_clr_n),
        .out_valid_o    (out_valid),
        .out_row_o      (out_row),
        .out_col_o      (out_col),
        .out_last_o     (out_last)
    );

    always #5 clk = ~clk;

    // Runs one map starting from a post-negedge slot; cycle 0 is the start cycle.
    task automatic run_map(input int stall_pct, input bit poke, input int abort_after);
        int   cyc = 0, pr = 0, pc = 0, accepted = 0, last_acc = -1;
        int   done_cyc = 1 << 30, nres = 0, first = -1, lastv = -1, donev = -1, nlast = 0;
        bit   fin = 1'b0;
        bit   acc, exp_ready;
        exp_t e;
        sb.delete();
        nov.delete();
        for (int k = 0; k < 6000; k++) begin
            if (nov.size() > 0 && nov[0] == cyc) begin
                void'(nov.pop_front());
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL row_wrap cyc=%0d out_valid=%b required=0", cyc, out_valid);
                end
            end
            if (out_valid === 1'b1) begin
                if (first < 0) first = cyc;
                nres++;
                if (out_last === 1'b1) begin
                    lastv = cyc;
                    nlast++;
                end
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL stray_result cyc=%0d row=%0d col=%0d", cyc, out_row, out_col);
                end else begin
                    e = sb.pop_front();
                    if (e.cyc != cyc || int'(out_row) != e.row || int'(out_col) != e.col ||
                        out_last !== e.last) begin
                        errors++;
                        $display("FAIL result cyc=%0d got (%0d,%0d,last=%b) required cyc=%0d (%0d,%0d,last=%b)",
                                 cyc, out_row, out_col, out_last, e.cyc, e.row, e.col, e.last);
                    end
                end
            end else if (sb.size() > 0 && sb[0].cyc == cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_result cyc=%0d out_valid=%b required (%0d,%0d)",
                         cyc, out_valid, sb[0].row, sb[0].col);
                void'(sb.pop_front());
            end
            checks++;
            if (conv_clr_n !== (cyc != 1)) begin
                errors++;
                $display("FAIL clr_n cyc=%0d got=%b required=%b", cyc, conv_clr_n, cyc != 1);
            end
            checks++;
            if (busy !== (cyc >= 1 && cyc <= done_cyc)) begin
                errors++;
                $display("FAIL busy cyc=%0d got=%b required=%b", cyc, busy, cyc >= 1 && cyc <= done_cyc);
            end
            checks++;
            if (done !== (cyc == done_cyc)) begin
                errors++;
                $display("FAIL done cyc=%0d got=%b required=%b", cyc, done, cyc == done_cyc);
            end
            if (done === 1'b1) donev = cyc;
            if (cyc == done_cyc + 1) begin
                fin = 1'b1;
                break;
            end

            start = (cyc == 0) ||
                    (poke && (cyc == 300 || (last_acc > 0 && (cyc == last_acc + 1 || cyc == last_acc + 2))));
            in_valid = ($urandom_range(99) >= stall_pct);
            #1;
            exp_ready = (cyc >= 2) && (last_acc < 0);
            checks++;
            if (in_ready !== exp_ready) begin
                errors++;
                $display("FAIL in_ready cyc=%0d got=%b required=%b", cyc, in_ready, exp_ready);
            end
            acc = in_valid && exp_ready;
            checks++;
            if (conv_shift_n !== !acc) begin
                errors++;
                $display("FAIL shift_n cyc=%0d got=%b required=%b", cyc, conv_shift_n, !acc);
            end
            if (acc) begin
                if (pr >= 4 && pc >= 4) begin
                    e.cyc  = cyc + LAT;
                    e.row  = pr - 4;
                    e.col  = pc - 4;
                    e.last = (pr == MS - 1 && pc == MS - 1);
                    sb.push_back(e);
                end else if (pr == 6) begin
                    nov.push_back(cyc + LAT);
                end
                accepted++;
                if (pc == MS - 1) begin
                    pc = 0;
                    pr++;
                end else begin
                    pc++;
                end
                if (accepted == MS * MS) begin
                    last_acc = cyc;
                    done_cyc = cyc + 1 + LAT;
                end
            end
            @(posedge clk);
            if (abort_after > 0 && accepted == abort_after) begin
                #2;
                rst = 1'b0;
                #1;
                checks++;
                if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0 || conv_shift_n !== 1'b1 ||
                    conv_clr_n !== 1'b1 || out_valid !== 1'b0 || out_row !== 5'd0 ||
                    out_col !== 5'd0 || out_last !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_reset busy=%b done=%b rdy=%b sh=%b clr=%b v=%b r=%0d c=%0d l=%b required 0,0,0,1,1,0,0,0,0",
                             busy, done, in_ready, conv_shift_n, conv_clr_n, out_valid, out_row, out_col, out_last);
                end
                in_valid = 1'b0;
                start    = 1'b0;
                repeat (3) @(negedge clk);
                rst = 1'b1;
                for (int j = 0; j < 5; j++) begin
                    @(negedge clk);
                    checks++;
                    if (out_valid !== 1'b0 || busy !== 1'b0) begin
                        errors++;
                        $display("FAIL abort_quiet out_valid=%b busy=%b required 0,0", out_valid, busy);
                    end
                end
                sb.delete();
                nov.delete();
                return;
            end
            cyc++;
            @(negedge clk);
        end
        start    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (!fin || sb.size() != 0) begin
            errors++;
            $display("FAIL map_complete finished=%b pending=%0d required 1,0", fin, sb.size());
        end
        res_first = first;
        res_lastv = lastv;
        res_donev = donev;
        res_count = nres;
        res_nlast = nlast;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_busy busy=%b in_ready=%b required 1,1", busy, in_ready);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0 || conv_shift_n !== 1'b1 ||
            conv_clr_n !== 1'b1 || out_valid !== 1'b0 || out_row !== 5'd0 ||
            out_col !== 5'd0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_values busy=%b done=%b rdy=%b sh=%b clr=%b v=%b r=%0d c=%0d l=%b required 0,0,0,1,1,0,0,0,0",
                     busy, done, in_ready, conv_shift_n, conv_clr_n, out_valid, out_row, out_col, out_last);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (busy !== 1'b0 || in_ready !== 1'b0 || conv_shift_n !== 1'b1 ||
                conv_clr_n !== 1'b1 || out_valid !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL idle_quiet i=%0d busy=%b rdy=%b sh=%b clr=%b v=%b done=%b required 0,0,1,1,0,0",
                         i, busy, in_ready, conv_shift_n, conv_clr_n, out_valid, done);
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_continuous();
        run_map(0, 1'b0, 0);
        checks++;
        if (res_first != 136 || res_lastv != 1027 || res_donev != 1028 ||
            res_count != NRES || res_nlast != 1) begin
            errors++;
            $display("FAIL continuous first=%0d last=%0d done=%0d n=%0d nlast=%0d required 136,1027,1028,%0d,1",
                     res_first, res_lastv, res_donev, res_count, res_nlast, NRES);
        end
    endtask

    task automatic test_stalls();
        run_map(50, 1'b0, 0);
        checks++;
        if (res_count != NRES || res_nlast != 1) begin
            errors++;
            $display("FAIL stalls n=%0d nlast=%0d required %0d,1", res_count, res_nlast, NRES);
        end
    endtask

    task automatic test_start_ignored();
        run_map(0, 1'b1, 0);
        checks++;
        if (res_count != NRES || res_donev != 1028 || res_lastv != 1027) begin
            errors++;
            $display("FAIL start_ignored n=%0d done=%0d last=%0d required %0d,1028,1027",
                     res_count, res_donev, res_lastv, NRES);
        end
    endtask

    task automatic test_back_to_back();
        for (int m = 0; m < 2; m++) begin
            run_map(0, 1'b0, 0);
            checks++;
            if (res_first != 136 || res_donev != 1028 || res_count != NRES) begin
                errors++;
                $display("FAIL back_to_back map=%0d first=%0d done=%0d n=%0d required 136,1028,%0d",
                         m, res_first, res_donev, res_count, NRES);
            end
        end
    endtask

    task automatic test_reset_mid_map();
        run_map(0, 1'b0, 500);
        run_map(0, 1'b0, 0);
        checks++;
        if (res_count != NRES || res_first != 136 || res_donev != 1028) begin
            errors++;
            $display("FAIL after_abort n=%0d first=%0d done=%0d required %0d,136,1028",
                     res_count, res_first, res_donev, NRES);
        end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_stalls();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_map();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv55_ctrl.md
# conv55_ctrl

Sequencing controller for the 5x5 convolution engine. It takes a MAP_SIZE x MAP_SIZE feature map as a raster pixel stream over a valid/ready handshake. It clears the engine's line buffer, drives the engine's active-low shift enable once per accepted pixel, and suppresses windows that are not yet filled or that wrap across a row. It tags every valid convolution result with its output coordinates, accounting for the engine's multiplier latency, and signals end of map. It sits between the pixel source (feature-map buffer) and the engine / downstream pooling stage.

## Interface

Parameters:
- MAP_SIZE, 32, input map width and height in pixels (≥ 6)
- MULT_LAT, 1, register stages between the engine window registers and a valid convValue (≥ 1)

Derived widths:
- CW = $clog2(MAP_SIZE)
- OW = $clog2(MAP_SIZE-4)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  begin one map; sampled only in IDLE
- busy  out  1  high from CLEAR through DONE inclusive
- done  out  1  one-cycle pulse in DONE state
- in_valid  in  1  source has a pixel
- in_ready  out  1  controller accepts a pixel this cycle
- conv_shift_n  out  1  to engine en; 0 = shift in pixel; equals ~(in_valid & in_ready)
- conv_clr_n  out  1  to engine rst; low for exactly the CLEAR cycle
- out_valid  out  1  engine convValue is a valid window result this cycle
- out_row  out  OW  output row of current result
- out_col  out  OW  output column of current result
- out_last  out  1  high with out_valid on result (MAP_SIZE-5, MAP_SIZE-5)

## Operation

- FSM states: IDLE, CLEAR, STREAM, DRAIN, DONE.
  - IDLE: in_ready=0. start=1 → CLEAR.
  - CLEAR: one cycle; conv_clr_n=0; pixel counters r, c cleared → STREAM.
  - STREAM: in_ready=1. Each accept (in_valid & in_ready) advances c; when c wraps from MAP_SIZE-1 to 0, r increments. When the accepted pixel is (MAP_SIZE-1, MAP_SIZE-1) → DRAIN.
  - DRAIN: in_ready=0; lasts 1+MULT_LAT cycles (down-counter) → DONE.
  - DONE: done=1 for one cycle → IDLE.
- Window qualification: the accept of pixel (r,c) with r≥4 and c≥4 produces a result at (r-4, c-4). All other accepts produce none; c<4 windows straddle a row boundary in the line buffer.
- Tag pipeline:
  - Depth 1+MULT_LAT shift register of {valid, row, col, last}, advanced every cycle (free-running, matches engine multiplier pipeline).
  - Stage 0 loads the tag on accept, else valid=0.
  - Output stage drives out_valid, out_row, out_col, out_last.
- No output backpressure: the sink must accept every out_valid.
- Source stalls (in_valid=0) insert gaps. conv_shift_n stays 1 so the engine window holds.
- start in any state other than IDLE is ignored.
- in_valid while in_ready=0 is ignored; nothing is accepted and conv_shift_n=1.
- Reset (any time, including mid-map): FSM→IDLE, counters and tag pipeline cleared, all outputs to reset values. The next start re-clears the engine.

## Timing

- Reset values: busy=0, done=0, in_ready=0, conv_shift_n=1, conv_clr_n=1, out_valid=0, out_row=0, out_col=0, out_last=0.
- start sampled in cycle 0 → CLEAR in cycle 1 → STREAM from cycle 2.
- Pixel accepted in cycle t → its result (if qualified) appears with out_valid in cycle t+1+MULT_LAT.
- Continuous stream, MAP_SIZE=32, MULT_LAT=1:
  - Pixel k accepted in cycle 2+k.
  - First out_valid in cycle 136, at (0,0).
  - Last pixel accepted in cycle 1025.
  - DRAIN in cycles 1026–1027.
  - Final out_valid and out_last in cycle 1027, at (27,27).
  - done in cycle 1028; IDLE and busy=0 in cycle 1029.
- Results per map: exactly (MAP_SIZE-4)², in raster order.
- out_last is asserted once per map.

## Test plan

- Reset: assert rst mid-cycle → all outputs equal their reset values immediately; release, idle 10 cycles → no activity.
- Continuous 32x32 map of pixel value (r*32+c)&0x7F, MULT_LAT=1, start at cycle 0 → all of the following hold:
  - conv_clr_n low in cycle 1 only.
  - First out_valid in cycle 136 at (0,0).
  - 784 results in raster order.
  - out_last in cycle 1027 at (27,27).
  - done in cycle 1028.
  - Engine output matches the golden 5x5 convolution.
- Random 50% in_valid stalls → conv_shift_n low only on accept cycles; each out_valid arrives exactly 2 cycles after the accepting cycle; still 784 results with identical values.
- Row-wrap suppression: watch accepts of pixels (6,0)..(6,3) → no out_valid 2 cycles later; the (6,4) accept yields out_valid at (2,0).
- start pulsed during STREAM and DRAIN → ignored, count unchanged. Back-to-back maps with start in the cycle after done → second map identical to the first, including the clr pulse.
- rst asserted after pixel 500 → outputs reset at once with no stray out_valid. New start → a full, correct 784-result map.
